// File: rtl/pb_conditioner_if.sv
// Push-button conditioner signal bundle.
// Raw buttons in, count pulses and debug LEDs out.
interface pb_conditioner_if;
  logic       pbl;
  logic       pbr;
  logic       cntdwn;
  logic       cntup;
  logic [3:0] status;

  modport master (
    output pbl,
    output pbr,
    input  cntdwn,
    input  cntup,
    input  status
  );

  modport slave (
    input  pbl,
    input  pbr,
    output cntdwn,
    output cntup,
    output status
  );
endinterface

// File: rtl/pb_conditioner.sv
// Two-button synchronizer/debouncer with rising-edge count pulses.
// Optional auto-repeat while held: define PB_AUTOREPEAT_EN.
module pb_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_CYCLES   = 50000
) (
  input logic            clk,
  input logic            rst,
  pb_conditioner_if.slave pb
);

  localparam logic [15:0] DEB_LAST =
    16'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 ||
      REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535)
  begin : g_bad_param
    $error("pb_conditioner: parameter out of range");
  end

  logic [1:0] raw;
  logic [1:0] deb_v;
  logic [1:0] pulse_v;

  assign raw = {pb.pbr, pb.pbl};

  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic        s1;
    logic        s2;
    logic        deb;
    logic        pulse;
    logic [15:0] cnt;
    logic        accept;
    logic        rpt_fire;

    assign accept = (s2 != deb) && (cnt == DEB_LAST);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        deb   <= 1'b0;
        cnt   <= '0;
        pulse <= 1'b0;
      end else begin
        s1    <= raw[i];
        s2    <= s1;
        pulse <= (accept & s2) | rpt_fire;
        if (s2 == deb) begin
          cnt <= '0;
        end else if (accept) begin
          cnt <= '0;
          deb <= s2;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end
    end

`ifdef PB_AUTOREPEAT_EN
    localparam logic [15:0] RPT_LAST =
      16'(REPEAT_CYCLES - 1);

    logic [15:0] rcnt;

    // a release being accepted wins over a due repeat
    assign rpt_fire = deb && !accept &&
                      (rcnt == RPT_LAST);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rcnt <= '0;
      end else if (!deb) begin
        rcnt <= '0;
      end else if (rcnt == RPT_LAST) begin
        rcnt <= '0;
      end else begin
        rcnt <= rcnt + 16'd1;
      end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    assign deb_v[i]   = deb;
    assign pulse_v[i] = pulse;
  end

  assign pb.cntdwn = pulse_v[0];
  assign pb.cntup  = pulse_v[1];
  assign pb.status = {2'b11, ~deb_v[1], ~deb_v[0]};

endmodule

// File: tb/tb_pb_conditioner.sv
// Bench for pb_conditioner: directed scenarios plus
// random bouncing inputs against a run-length model.
module tb_pb_conditioner;

  localparam int D = 4;
  localparam int R = 8;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  pb_conditioner_if pb ();

  pb_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pb (pb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state per channel (0 = left, 1 = right)
  bit m_s1    [2];
  bit m_s2    [2];
  bit m_deb   [2];
  int m_run   [2];
  int m_since [2];
  bit m_pulse [2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pb.pbl = 1'b0;
    pb.pbr = 1'b0;
    rst    = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // one clock edge of the behavioural model
  task automatic model_step(input bit r0, input bit r1,
                            input bit rv);
    bit raw [2];
    raw[0] = r0;
    raw[1] = r1;
    for (int c = 0; c < 2; c++) begin
      m_pulse[c] = 1'b0;
      if (!rv) begin
        m_s1[c]    = 1'b0;
        m_s2[c]    = 1'b0;
        m_deb[c]   = 1'b0;
        m_run[c]   = 0;
        m_since[c] = 0;
      end else begin
        if (m_s2[c] != m_deb[c]) m_run[c]++;
        else m_run[c] = 0;
        if (m_run[c] == D) begin
          m_deb[c] = !m_deb[c];
          m_run[c] = 0;
          if (m_deb[c]) begin
            m_pulse[c] = 1'b1;
            m_since[c] = 0;
          end
        end
`ifdef PB_AUTOREPEAT_EN
        else if (m_deb[c]) begin
          m_since[c]++;
          if (m_since[c] == R) begin
            m_pulse[c] = 1'b1;
            m_since[c] = 0;
          end
        end
`endif
        m_s2[c] = m_s1[c];
        m_s1[c] = raw[c];
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pb.pbl = 1'($urandom_range(0, 1));
      pb.pbr = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (pb.cntdwn !== 1'b0 || pb.cntup !== 1'b0 ||
          pb.status !== 4'hF) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got %b%b %b want 00 1111",
                 i, pb.cntdwn, pb.cntup, pb.status);
      end
    end
    do_reset();
    pb.pbl = 1'b1;
    for (int i = 1; i <= 7; i++) tick();
    rst = 1'b0;
    #1;
    checks++;
    if (pb.status !== 4'hF || pb.cntdwn !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got st=%b dn=%b want 1111 0",
               pb.status, pb.cntdwn);
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] st;
    do_reset();
    pb.pbl = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      st = {3'b111, !(i >= D + 2)};
      checks++;
      if (pb.cntdwn !== (i == D + 2) || pb.cntup !== 1'b0 ||
          pb.status !== st) begin
        errors++;
        $display("FAIL clean_press i=%0d got %b%b %b want %b0 %b",
                 i, pb.cntdwn, pb.cntup, pb.status,
                 (i == D + 2), st);
      end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 1; i <= 14; i++) begin
      if (i == 1) pb.pbr = 1'b1;
      if (i == 3) pb.pbr = 1'b0;
      if (i == 4) pb.pbr = 1'b1;
      tick();
      checks++;
      if (pb.cntup !== (i == 9) || pb.cntdwn !== 1'b0) begin
        errors++;
        $display("FAIL bounce i=%0d got up=%b dn=%b want %b 0",
                 i, pb.cntup, pb.cntdwn, (i == 9));
      end
      if (i < 4) begin
        // input applied before the next edge: shift by one
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    pb.pbl = 1'b1;
    pb.pbr = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if (pb.cntdwn !== (i == D + 2) ||
          pb.cntup !== (i == D + 2)) begin
        errors++;
        $display("FAIL simultaneous i=%0d got %b%b want %b%b",
                 i, pb.cntdwn, pb.cntup,
                 (i == D + 2), (i == D + 2));
      end
    end
  endtask

  task automatic test_reset_mid_press();
    do_reset();
    pb.pbl = 1'b1;
    for (int i = 1; i <= 8; i++) tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (pb.cntdwn !== 1'b0 || pb.status !== 4'hF) begin
        errors++;
        $display("FAIL mid_press_rst i=%0d got dn=%b st=%b want 0 1111",
                 i, pb.cntdwn, pb.status);
      end
    end
    rst = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      checks++;
      if (pb.cntdwn !== (j == D + 2)) begin
        errors++;
        $display("FAIL mid_press_repress j=%0d got %b want %b",
                 j, pb.cntdwn, (j == D + 2));
      end
    end
  endtask

  task automatic test_hold();
    bit exp;
    int n;
    do_reset();
    pb.pbl = 1'b1;
    n = 0;
    for (int i = 1; i <= D + 2 + 39; i++) begin
      tick();
`ifdef PB_AUTOREPEAT_EN
      exp = (i >= D + 2) && ((i - (D + 2)) % R == 0);
`else
      exp = (i == D + 2);
`endif
      if (pb.cntdwn === 1'b1) n++;
      checks++;
      if (pb.cntdwn !== exp) begin
        errors++;
        $display("FAIL hold i=%0d got %b want %b",
                 i, pb.cntdwn, exp);
      end
    end
    checks++;
`ifdef PB_AUTOREPEAT_EN
    if (n != 5) begin
`else
    if (n != 1) begin
`endif
      errors++;
      $display("FAIL hold_count got %0d pulses", n);
    end
  endtask

  task automatic test_random();
    bit lvl  [2];
    int hold [2];
    logic [3:0] st;
    do_reset();
    model_step(1'b0, 1'b0, 1'b0);
    lvl[0] = 1'b0;
    lvl[1] = 1'b0;
    hold[0] = 0;
    hold[1] = 0;
    for (int n = 0; n < 800; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (hold[c] == 0) begin
          lvl[c] = !lvl[c];
          hold[c] = ($urandom_range(0, 3) == 0) ?
                    $urandom_range(5, 40) :
                    $urandom_range(1, 5);
        end
        hold[c]--;
      end
      pb.pbl = lvl[0];
      pb.pbr = lvl[1];
      rst = !(n == 400 || n == 401);
      tick();
      model_step(lvl[0], lvl[1], rst);
      st = {2'b11, !m_deb[1], !m_deb[0]};
      checks++;
      if (pb.cntdwn !== m_pulse[0] ||
          pb.cntup !== m_pulse[1] ||
          pb.status !== st) begin
        errors++;
        $display("FAIL random n=%0d got %b%b %b want %b%b %b",
                 n, pb.cntdwn, pb.cntup, pb.status,
                 m_pulse[0], m_pulse[1], st);
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    pb.pbl = 1'b0;
    pb.pbr = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid_press();
    test_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
